aes_cipher_out_serializer: RTL and testbench
============================================

Name: aes_cipher_out_serializer

Overview:
- Output-side counterpart of the plaintext file-input path.
- Accepts 128-bit cipher blocks from AES_top, buffers them in a small block FIFO, and streams each block out as 16 bytes over a valid/ready byte interface.
- The byte interface feeds the file writer or UART.
- Tracks completed blocks and flags upstream writes that ignore backpressure.

Parameters:
DEPTH, 4, FIFO depth in 128-bit blocks (power of 2, >=2)
MSB_FIRST, 1, 1: emit bits [127:120] first; 0: emit [7:0] first
CNT_W, 16, width of blk_count

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
blk_valid  in  1  upstream block present
blk_data  in  128  cipher block
blk_ready  out  1  FIFO can accept a block
byte_valid  out  1  byte_data valid
byte_data  out  8  serialized byte
byte_ready  in  1  downstream accepts byte
byte_last  out  1  high with 16th byte of a block
blk_count  out  CNT_W  blocks fully emitted, wraps modulo 2^CNT_W
overflow  out  1  sticky: blk_valid seen while FIFO full

Behaviour:
- Reset (rst sampled high):
  - FIFO pointers and occupancy go to 0; FSM goes to IDLE.
  - byte_valid=0, byte_last=0, byte_data=0, blk_count=0, overflow=0.
  - blk_ready = !full && !rst, so it is 0 while rst is high and 1 the cycle after.
- Reset mid-operation:
  - Partial block and all queued blocks are discarded.
  - byte_valid drops after the edge where rst is sampled.
  - No byte_last is emitted for the dropped block.
- FIFO:
  - Push on blk_valid && blk_ready.
  - blk_ready = !full, and depends only on occupancy. A simultaneous pop does not enable a push into a full FIFO.
  - Pop is internal, issued by the FSM.
  - Occupancy counter is DEPTH+1 states wide; full is occupancy==DEPTH, empty is occupancy==0.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop leave occupancy unchanged.
- Overflow: blk_valid && full sets overflow. The block is not written. overflow clears only on rst.
- FSM states:
  - IDLE: if !empty, pop the FIFO head into the 128-bit shift register, set idx=0, go to SEND. Otherwise stay.
  - SEND:
    - byte_valid=1.
    - byte_data = current byte: top byte of shift register if MSB_FIRST=1, else bottom byte.
    - On byte_valid && byte_ready: shift by 8 and increment idx.
    - When idx==15 handshakes: blk_count+1 (wraps), go to IDLE.
  - byte_last = byte_valid && idx==15.
- Latency:
  - Block pushed at edge t into an empty FIFO, FSM in IDLE: empty deasserts after t, pop/load at edge t+1, byte_valid high after t+1.
  - With byte_ready held 1: 16 consecutive bytes, then exactly one idle cycle (IDLE) before the next block's first byte.
  - Sustained throughput is 16 bytes per 17 cycles.
- Backpressure: while byte_valid && !byte_ready, byte_data, byte_last and idx hold stable. byte_valid never deasserts without a handshake, except on rst.
- byte_ready while byte_valid=0 has no effect.

Decomposition:
- Shared package aes_pkg:
  - AES_BLOCK_W=128, AES_BYTES=16.
  - FSM state typedef {IDLE, SEND}.
  - byte-index width constant (4).
- One natural sub-module: aes_block_fifo (parameterised DEPTH x 128 synchronous FIFO with push/pop/full/empty/occupancy).
- Serializer FSM, counters and overflow flag stay in the top.

Test Plan:
1. Single block, byte_ready=1, MSB_FIRST=1:
   - Stimulus: push 128'h100F0E0D0C0B0A090807060504030201.
   - Response: bytes 10,0F,0E,...,02,01 on 16 consecutive cycles; first byte 2 cycles after push; byte_last only on 01; blk_count=1.
2. Backpressure, same block:
   - Stimulus: byte_ready toggles 1,0,0,1,... pseudo-randomly.
   - Response: each byte held stable while stalled; sequence identical to scenario 1; no duplicates, no losses.
3. Fill, DEPTH=4, byte_ready=0:
   - Stimulus: push 5 blocks 00FFFEFD...F1, F0EF...E1, E0DF...D1, D0CF...C1, C0BF...B1, keeping blk_valid high.
   - Response:
     - First block is popped into the shift register, so 4 more are accepted and blk_ready falls after the 5th push.
     - A 6th blk_valid while full sets overflow=1.
     - Releasing byte_ready emits 80 bytes in push order, one idle cycle between blocks; blk_count=5.
4. Reset mid-block:
   - Stimulus: assert rst for 1 cycle after the 7th byte of 100F...01, with 2 blocks queued.
   - Response: byte_valid=0 the next cycle; blk_count=0; overflow=0; blk_ready=1 one cycle after rst falls; no further bytes until a new push.
5. MSB_FIRST=0:
   - Stimulus: push 100F...01.
   - Response: bytes 01,02,...,0F,10; byte_last on 10.
6. CNT_W=4:
   - Stimulus: stream 17 blocks with byte_ready=1.
   - Response: blk_count reads 15 after block 15, 0 after block 16, 1 after block 17.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and types for the AES cipher-output path.
//   AES_BLOCK_W : width of one cipher block in bits
//   AES_BYTES   : bytes per cipher block
//   AES_IDX_W   : width of the byte index within a block
//   ser_state_e : serializer FSM state encoding
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTES   = 16;
  localparam int AES_IDX_W   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/aes_block_fifo.sv
// Synchronous block FIFO, DEPTH entries of W bits.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push          : write push_data (ignored while full)
//   push_data     : block to store
//   pop           : drop the head entry (ignored while empty)
//   pop_data      : current head entry (combinational read)
//   full, empty   : occupancy flags
// A simultaneous push and pop leaves the occupancy unchanged.
module aes_block_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (occ == FULL_OCC);
  assign empty    = (occ == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/aes_cipher_out_serializer.sv
// Buffers 128-bit cipher blocks and streams each as 16 bytes.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   blk_valid/blk_data/blk_ready : block input (push on valid && ready)
//   byte_valid/byte_data/byte_ready/byte_last : byte output stream
//   blk_count         : blocks fully emitted, wraps modulo 2^CNT_W
//   overflow          : sticky, blk_valid seen while the FIFO was full
//   fsm_state         : serializer state (0 = IDLE, 1 = SEND) for observation
// Handshake: a transfer happens on a rising edge where valid && ready. Once
// valid is raised, it and its payload hold until that transfer (reset is the
// only exception); ready may change freely and has no effect without valid.
module aes_cipher_out_serializer
  import aes_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   blk_valid,
  input  logic [AES_BLOCK_W-1:0] blk_data,
  output logic                   blk_ready,
  output logic                   byte_valid,
  output logic [7:0]             byte_data,
  input  logic                   byte_ready,
  output logic                   byte_last,
  output logic [CNT_W-1:0]       blk_count,
  output logic                   overflow,
  output logic                   fsm_state
);

  localparam logic [AES_IDX_W-1:0] LAST_IDX = AES_IDX_W'(AES_BYTES - 1);

  ser_state_e             state_q, state_d;
  logic [AES_BLOCK_W-1:0] sh_q;
  logic [AES_IDX_W-1:0]   idx_q;
  logic [AES_BLOCK_W-1:0] fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   load;
  logic                   shift;
  logic                   done;
  logic [7:0]             cur_byte;

  // Readiness depends on occupancy only, so a pop in the same cycle never
  // opens a slot for a push into a full FIFO.
  assign blk_ready = !fifo_full && !rst;

  aes_block_fifo #(
    .DEPTH (DEPTH),
    .W     (AES_BLOCK_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (blk_valid && blk_ready),
    .push_data (blk_data),
    .pop       (load),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (byte_ready) begin
          shift = 1'b1;
          if (idx_q == LAST_IDX) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cur_byte   = MSB_FIRST ? sh_q[AES_BLOCK_W-1 -: 8] : sh_q[7:0];
  assign byte_valid = (state_q == SEND);
  assign byte_data  = byte_valid ? cur_byte : 8'h00;
  assign byte_last  = byte_valid && (idx_q == LAST_IDX);
  assign fsm_state  = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      idx_q     <= '0;
      blk_count <= '0;
      overflow  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        sh_q  <= fifo_head;
        idx_q <= '0;
      end else if (shift) begin
        // Move the next byte into the output position.
        sh_q  <= MSB_FIRST ? {sh_q[AES_BLOCK_W-9:0], 8'h00}
                           : {8'h00, sh_q[AES_BLOCK_W-1:8]};
        idx_q <= idx_q + 1'b1;
      end
      if (done) blk_count <= blk_count + 1'b1;
      if (blk_valid && fifo_full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_cipher_out_serializer.sv
// Directed bench for aes_cipher_out_serializer. Three instances share all
// inputs: a_ uses defaults, b_ emits LSB first, c_ has a 4-bit block counter.
module tb_aes_cipher_out_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_valid;
  logic [127:0] blk_data;
  logic         byte_ready;

  logic a_blk_ready, a_byte_valid, a_byte_last, a_overflow, a_fsm_state;
  logic [7:0]  a_byte_data;
  logic [15:0] a_blk_count;
  logic b_blk_ready, b_byte_valid, b_byte_last, b_overflow, b_fsm_state;
  logic [7:0]  b_byte_data;
  logic [15:0] b_blk_count;
  logic c_blk_ready, c_byte_valid, c_byte_last, c_overflow, c_fsm_state;
  logic [7:0]  c_byte_data;
  logic [3:0]  c_blk_count;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];

  localparam logic [127:0] BLK_A = 128'h100F0E0D0C0B0A090807060504030201;

  always #5 clk = ~clk;

  aes_cipher_out_serializer u_a (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_data(blk_data),
    .blk_ready(a_blk_ready), .byte_valid(a_byte_valid), .byte_data(a_byte_data),
    .byte_ready(byte_ready), .byte_last(a_byte_last), .blk_count(a_blk_count),
    .overflow(a_overflow), .fsm_state(a_fsm_state)
  );

  aes_cipher_out_serializer #(.MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_data(blk_data),
    .blk_ready(b_blk_ready), .byte_valid(b_byte_valid), .byte_data(b_byte_data),
    .byte_ready(byte_ready), .byte_last(b_byte_last), .blk_count(b_blk_count),
    .overflow(b_overflow), .fsm_state(b_fsm_state)
  );

  aes_cipher_out_serializer #(.CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_data(blk_data),
    .blk_ready(c_blk_ready), .byte_valid(c_byte_valid), .byte_data(c_byte_data),
    .byte_ready(byte_ready), .byte_last(c_byte_last), .blk_count(c_blk_count),
    .overflow(c_overflow), .fsm_state(c_fsm_state)
  );

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Holds blk_valid until accepted; returns 1 time unit after the accepting edge.
  task automatic push_block(input logic [127:0] d);
    blk_data  = d;
    blk_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (a_blk_ready) begin
        @(posedge clk); #1;
        blk_valid = 1'b0;
        return;
      end
    end
    tests_run++; tests_failed++;
    $display("FAIL push_timeout: blk_ready stayed 0, required 1");
    blk_valid = 1'b0;
  endtask

  task automatic load_exp_msb(input logic [127:0] d);
    for (int k = 0; k < 16; k++) exp_q.push_back(d[127-8*k -: 8]);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; blk_valid = 1'b0; blk_data = '0; byte_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++; if (a_byte_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_byte_valid: got %b required 0", a_byte_valid); end
    tests_run++; if (a_byte_last !== 1'b0) begin tests_failed++; $display("FAIL rst_byte_last: got %b required 0", a_byte_last); end
    tests_run++; if (a_byte_data !== 8'h00) begin tests_failed++; $display("FAIL rst_byte_data: got %h required 00", a_byte_data); end
    tests_run++; if (a_blk_count !== 16'd0) begin tests_failed++; $display("FAIL rst_blk_count: got %0d required 0", a_blk_count); end
    tests_run++; if (a_overflow !== 1'b0) begin tests_failed++; $display("FAIL rst_overflow: got %b required 0", a_overflow); end
    tests_run++; if (a_blk_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_blk_ready_in_rst: got %b required 0", a_blk_ready); end
    tests_run++; if (a_fsm_state !== 1'b0) begin tests_failed++; $display("FAIL rst_fsm_state: got %b required 0", a_fsm_state); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (a_blk_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_blk_ready_after: got %b required 1", a_blk_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_block();
    logic [7:0] e;
    apply_reset();
    byte_ready = 1'b1;
    exp_q.delete();
    load_exp_msb(BLK_A);
    push_block(BLK_A);
    @(negedge clk);
    tests_run++; if (a_byte_valid !== 1'b0) begin tests_failed++; $display("FAIL single_latency: byte_valid got %b required 0", a_byte_valid); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      tests_run++; if (a_byte_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid[%0d]: got %b required 1", k, a_byte_valid); end
      tests_run++; if (a_byte_data !== e) begin tests_failed++; $display("FAIL single_data[%0d]: got %h required %h", k, a_byte_data, e); end
      tests_run++; if (a_byte_last !== (k == 15)) begin tests_failed++; $display("FAIL single_last[%0d]: got %b required %b", k, a_byte_last, (k == 15)); end
    end
    @(negedge clk);
    tests_run++; if (a_byte_valid !== 1'b0) begin tests_failed++; $display("FAIL single_idle: byte_valid got %b required 0", a_byte_valid); end
    tests_run++; if (a_blk_count !== 16'd1) begin tests_failed++; $display("FAIL single_count: got %0d required 1", a_blk_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [3:0] pat = 4'b1001;
    logic       held = 1'b0;
    logic [7:0] hd = 8'h00;
    logic       hl = 1'b0;
    logic [7:0] e;
    int k = 0;
    apply_reset();
    byte_ready = 1'b0;
    exp_q.delete();
    load_exp_msb(BLK_A);
    push_block(BLK_A);
    for (int cyc = 0; cyc < 300 && k < 16; cyc++) begin
      byte_ready = (cyc < 4) ? pat[3-cyc] : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (a_byte_valid) begin
        if (held) begin
          tests_run++; if (a_byte_data !== hd) begin tests_failed++; $display("FAIL bp_hold_data: got %h required %h", a_byte_data, hd); end
          tests_run++; if (a_byte_last !== hl) begin tests_failed++; $display("FAIL bp_hold_last: got %b required %b", a_byte_last, hl); end
        end
        if (byte_ready) begin
          e = exp_q.pop_front();
          tests_run++; if (a_byte_data !== e) begin tests_failed++; $display("FAIL bp_data[%0d]: got %h required %h", k, a_byte_data, e); end
          tests_run++; if (a_byte_last !== (k == 15)) begin tests_failed++; $display("FAIL bp_last[%0d]: got %b required %b", k, a_byte_last, (k == 15)); end
          k++;
          held = 1'b0;
        end else begin
          held = 1'b1; hd = a_byte_data; hl = a_byte_last;
        end
      end
      @(posedge clk); #1;
    end
    tests_run++; if (k !== 16) begin tests_failed++; $display("FAIL bp_byte_total: got %0d required 16", k); end
    byte_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (a_byte_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_no_dup: byte_valid got %b required 0", a_byte_valid); end
    tests_run++; if (a_blk_count !== 16'd1) begin tests_failed++; $display("FAIL bp_count: got %0d required 1", a_blk_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_fill_overflow();
    logic [127:0] blk [5];
    logic [7:0]   e;
    int n = 0;
    int first_cyc = 0;
    blk[0] = 128'h00FFFEFDFCFBFAF9F8F7F6F5F4F3F2F1;
    blk[1] = 128'hF0EFEEEDECEBEAE9E8E7E6E5E4E3E2E1;
    blk[2] = 128'hE0DFDEDDDCDBDAD9D8D7D6D5D4D3D2D1;
    blk[3] = 128'hD0CFCECDCCCBCAC9C8C7C6C5C4C3C2C1;
    blk[4] = 128'hC0BFBEBDBCBBBAB9B8B7B6B5B4B3B2B1;
    apply_reset();
    byte_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      load_exp_msb(blk[i]);
      push_block(blk[i]);
    end
    @(negedge clk);
    tests_run++; if (a_blk_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_full: blk_ready got %b required 0", a_blk_ready); end
    tests_run++; if (a_overflow !== 1'b0) begin tests_failed++; $display("FAIL fill_no_ovf_yet: got %b required 0", a_overflow); end
    @(posedge clk); #1;
    blk_data = {16{8'hAA}};
    blk_valid = 1'b1;
    @(posedge clk); #1;
    blk_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (a_overflow !== 1'b1) begin tests_failed++; $display("FAIL fill_overflow: got %b required 1", a_overflow); end
    tests_run++; if (a_byte_data !== 8'h00) begin tests_failed++; $display("FAIL fill_stalled_head: got %h required 00", a_byte_data); end
    @(posedge clk); #1;
    byte_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && n < 80; cyc++) begin
      @(negedge clk);
      if (a_byte_valid) begin
        if (n == 0) first_cyc = cyc;
        e = exp_q.pop_front();
        tests_run++; if (a_byte_data !== e) begin tests_failed++; $display("FAIL fill_data[%0d]: got %h required %h", n, a_byte_data, e); end
        tests_run++; if (a_byte_last !== ((n % 16) == 15)) begin tests_failed++; $display("FAIL fill_last[%0d]: got %b required %b", n, a_byte_last, ((n % 16) == 15)); end
        tests_run++; if ((cyc - first_cyc) !== (n + n / 16)) begin tests_failed++; $display("FAIL fill_timing[%0d]: cycle %0d required %0d", n, cyc - first_cyc, n + n / 16); end
        n++;
      end
    end
    tests_run++; if (n !== 80) begin tests_failed++; $display("FAIL fill_byte_total: got %0d required 80", n); end
    @(negedge clk);
    tests_run++; if (a_byte_valid !== 1'b0) begin tests_failed++; $display("FAIL fill_extra_byte: byte_valid got %b required 0", a_byte_valid); end
    tests_run++; if (a_blk_count !== 16'd5) begin tests_failed++; $display("FAIL fill_count: got %0d required 5", a_blk_count); end
    tests_run++; if (a_overflow !== 1'b1) begin tests_failed++; $display("FAIL fill_ovf_sticky: got %b required 1", a_overflow); end
  endtask

  // Runs straight after the fill scenario, so overflow and blk_count start nonzero.
  task automatic test_reset_mid_block();
    int n = 0;
    int stray = 0;
    @(posedge clk); #1;
    byte_ready = 1'b0;
    push_block(BLK_A);
    push_block({16{8'h55}});
    push_block({16{8'h66}});
    byte_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && n < 7; cyc++) begin
      @(negedge clk);
      if (a_byte_valid && byte_ready) n++;
    end
    tests_run++; if (n !== 7) begin tests_failed++; $display("FAIL mid_pre_bytes: got %0d required 7", n); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if (a_blk_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_ready_in_rst: got %b required 0", a_blk_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (a_byte_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_valid_drop: got %b required 0", a_byte_valid); end
    tests_run++; if (a_blk_count !== 16'd0) begin tests_failed++; $display("FAIL mid_count: got %0d required 0", a_blk_count); end
    tests_run++; if (a_overflow !== 1'b0) begin tests_failed++; $display("FAIL mid_overflow: got %b required 0", a_overflow); end
    tests_run++; if (a_blk_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_ready_after: got %b required 1", a_blk_ready); end
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (a_byte_valid || a_byte_last) stray++;
    end
    tests_run++; if (stray !== 0) begin tests_failed++; $display("FAIL mid_stray_bytes: got %0d required 0", stray); end
    @(posedge clk); #1;
  endtask

  task automatic test_lsb_first();
    int k = 0;
    apply_reset();
    byte_ready = 1'b1;
    push_block(BLK_A);
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (b_byte_valid) begin
        if (k < 16) begin
          tests_run++; if (b_byte_data !== 8'(k + 1)) begin tests_failed++; $display("FAIL lsb_data[%0d]: got %h required %h", k, b_byte_data, 8'(k + 1)); end
          tests_run++; if (b_byte_last !== (k == 15)) begin tests_failed++; $display("FAIL lsb_last[%0d]: got %b required %b", k, b_byte_last, (k == 15)); end
        end
        k++;
      end
    end
    tests_run++; if (k !== 16) begin tests_failed++; $display("FAIL lsb_byte_total: got %0d required 16", k); end
    tests_run++; if (b_blk_count !== 16'd1) begin tests_failed++; $display("FAIL lsb_count: got %0d required 1", b_blk_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_count_wrap();
    int nblk = 0;
    apply_reset();
    byte_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 17; i++) push_block({16{8'(i + 1)}});
      end
      begin
        for (int cyc = 0; cyc < 800 && nblk < 17; cyc++) begin
          @(negedge clk);
          if (c_byte_valid && c_byte_last) begin
            nblk++;
            @(negedge clk);
            tests_run++; if (c_blk_count !== 4'(nblk % 16)) begin tests_failed++; $display("FAIL wrap_count[%0d]: got %0d required %0d", nblk, c_blk_count, nblk % 16); end
          end
        end
      end
    join
    tests_run++; if (nblk !== 17) begin tests_failed++; $display("FAIL wrap_block_total: got %0d required 17", nblk); end
    tests_run++; if (a_blk_count !== 16'd17) begin tests_failed++; $display("FAIL wrap_wide_count: got %0d required 17", a_blk_count); end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_backpressure();
    test_fill_overflow();
    test_reset_mid_block();
    test_lsb_first();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
